// File: rtl/alu_pkg.sv
// Shared definitions for the Mini-ALU initiator blocks: operand width,
// ALU control codes, sequencer state encoding and opcode legality check.
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SLL,
            OP_XOR, OP_SUB, OP_SRA, OP_SLT: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_resp_reg.sv
// Response holding register: captures a result on load and holds it
// stable on the valid/ready stream until the consumer takes it.
module alu_resp_reg #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_carry,
    input  logic         load_zero,
    input  logic         load_err,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         carry,
    output logic         zero,
    output logic         err
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            carry <= load_carry;
            zero  <= load_zero;
            err   <= load_err;
        end else if (valid && ready) begin
            // payload is left in place; only the valid flag drops
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the combinational Mini-ALU: takes commands, drives registered
// operands, captures the ALU result one cycle later and returns it as a response.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_err,
    output logic [CNT_W-1:0] done_count
);

    state_t           state_reg, state_next;
    logic             live_reg;
    logic [3:0]       ctrl_reg;
    logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic             load_cmd, capture, legal;

    // live_reg keeps cmd_ready low while reset is held and for the first edge after it
    assign cmd_ready = live_reg &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_RESP) && res_ready));
    assign legal     = is_legal_op(ctrl_reg);

    always_comb begin
        state_next = state_reg;
        load_cmd   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load_cmd   = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture    = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    if (cmd_valid && cmd_ready) begin
                        load_cmd   = 1'b1;
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            live_reg  <= 1'b0;
            ctrl_reg  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            live_reg  <= 1'b1;
            if (load_cmd) begin
                ctrl_reg <= cmd_op;
                a_reg    <= cmd_use_acc ? acc_reg : cmd_a;
                b_reg    <= cmd_b;
            end
            if (capture && legal) begin
                acc_reg <= alu_out;
            end
            if (res_valid && res_ready) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // illegal opcodes report an error with all result fields forced to zero
    alu_resp_reg #(.W(WIDTH)) u_resp (
        .clk        (clk),
        .rst        (rst),
        .load       (capture),
        .load_data  (legal ? alu_out : '0),
        .load_carry (legal & alu_carry),
        .load_zero  (legal & alu_zero),
        .load_err   (~legal),
        .ready      (res_ready),
        .valid      (res_valid),
        .data       (res_data),
        .carry      (res_carry),
        .zero       (res_zero),
        .err        (res_err)
    );

    assign alu_ctrl   = ctrl_reg;
    assign alu_a      = a_reg;
    assign alu_b      = b_reg;
    assign done_count = count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised scoreboard bench for alu_cmd_sequencer with a behavioural Mini-ALU attached.
module tb_alu_cmd_sequencer;

    localparam int W  = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_use_acc;
    logic [3:0]    cmd_op;
    logic [W-1:0]  cmd_a, cmd_b;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic          alu_carry, alu_zero;
    logic          res_valid, res_ready, res_carry, res_zero, res_err;
    logic [W-1:0]  res_data;
    logic [CW-1:0] done_count;

    typedef struct packed {
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
        logic         err;
    } resp_t;

    resp_t        exp_q[$];
    int           checks = 0;
    int           passed = 0;
    int           cyc = 0;
    int           m_done = 0;
    logic [W-1:0] m_acc = '0;
    logic         acc_d1 = 1'b0, acc_d2 = 1'b0;
    int           last_accept = -1, last_consume = -1;
    logic         rand_rdy = 1'b0, rdy_force = 1'b1;

    alu_cmd_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err),
        .done_count(done_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Mini-ALU semantics, returned as {carry, zero, out}; undefined codes give junk
    function automatic logic [W+1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] o;
        logic         c;
        c = 1'b0;
        case (op)
            4'h0: o = a & b;
            4'h1: o = a | b;
            4'h2: begin s = {1'b0, a} + {1'b0, b}; o = s[W-1:0]; c = s[W]; end
            4'h3: o = a << b[2:0];
            4'h4: o = a ^ b;
            4'h6: begin o = a - b; c = (a < b); end
            4'h7: o = $signed(a) >>> b[2:0];
            4'h8: o = ($signed(a) < $signed(b)) ? 6'd1 : 6'd0;
            default: begin o = 6'h2A; c = 1'b1; end
        endcase
        return {c, (o == '0), o};
    endfunction

    always_comb {alu_carry, alu_zero, alu_out} = alu_fn(alu_ctrl, alu_a, alu_b);

    always @(posedge clk) begin
        #1;
        res_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // reference: what the response for this command must be, given the running accumulator
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ua);
        logic [W+1:0] r;
        logic [W-1:0] ea;
        resp_t        e;
        int           n;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL accept_timeout: cmd_ready stayed 0, required 1");
                cmd_valid = 1'b0;
                return;
            end
        end
        last_accept = cyc + 1;
        @(posedge clk);
        ea = ua ? m_acc : a;
        r  = alu_fn(op, ea, b);
        if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8}) begin
            e = '{data: r[W-1:0], carry: r[W+1], zero: r[W], err: 1'b0};
            m_acc = r[W-1:0];
        end else begin
            e = '{data: '0, carry: 1'b0, zero: 1'b0, err: 1'b1};
        end
        exp_q.push_back(e);
        $display("cmd op=%h a=%h b=%h use_acc=%0d -> expect data=%h c=%0d z=%0d err=%0d",
                 op, ea, b, ua, e.data, e.carry, e.zero, e.err);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d responses pending, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_done = 0;
            acc_d1 = 1'b0;
            acc_d2 = 1'b0;
        end else begin
            check("done_count", 32'(done_count), 32'(m_done % 256));
            if (acc_d2) check("latency_valid", 32'(res_valid), 32'd1);
            if (acc_d1) check("exec_gap", 32'(res_valid), 32'd0);
            acc_d2 = acc_d1;
            acc_d1 = cmd_valid && cmd_ready;
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: res_valid=1 data=%h, required no response", res_data);
                end else begin
                    check("res_data", 32'(res_data), 32'(exp_q[0].data));
                    check("res_carry", 32'(res_carry), 32'(exp_q[0].carry));
                    check("res_zero", 32'(res_zero), 32'(exp_q[0].zero));
                    check("res_err", 32'(res_err), 32'(exp_q[0].err));
                    if (!res_ready) begin
                        check("cmd_ready_hold", 32'(cmd_ready), 32'd0);
                    end else begin
                        $display("resp data=%h c=%0d z=%0d err=%0d", res_data, res_carry, res_zero, res_err);
                        void'(exp_q.pop_front());
                        m_done++;
                        last_consume = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_res_flags"}, 32'({res_carry, res_zero, res_err}), 32'd0);
        check({tag, "_done_count"}, 32'(done_count), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_acc = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        int first_acc;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk) check("ready_first_cycle", 32'(cmd_ready), 32'd0);
        @(negedge clk) check("ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        send(4'h2, 6'h30, 6'h20, 1'b0);
        drain();

        // reset while the command sits in EXEC: nothing may come back
        send(4'h2, 6'h11, 6'h01, 1'b0);
        #1 rst = 1'b1;
        #1 check_all_zero("rst_exec");
        @(posedge clk); #1 rst = 1'b0;
        m_acc = '0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        send(4'h2, 6'h00, 6'h00, 1'b1);
        drain();

        send(4'h6, 6'h05, 6'h05, 1'b0);
        send(4'h2, 6'h00, 6'h07, 1'b1);
        send(4'h5, 6'h3F, 6'h01, 1'b0);
        send(4'h0, 6'h00, 6'h3F, 1'b1);
        drain();

        // consumer stalls; the next command must go in on the releasing edge
        rdy_force = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        send(4'h4, 6'h15, 6'h0F, 1'b0);
        fork
            send(4'h1, 6'h21, 6'h12, 1'b0);
            begin repeat (6) @(negedge clk); rdy_force = 1'b1; end
        join
        check("same_cycle_accept", 32'(last_accept), 32'(last_consume));
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send(4'($urandom_range(0, 15)), 6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        drain();

        pulse_reset();
        first_acc = -1;
        for (int i = 0; i < 256; i++) begin
            send(4'($urandom_range(0, 8)), 6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
            if (i == 0) first_acc = last_accept;
        end
        check("throughput_cycles", 32'(last_accept - first_acc), 32'd510);
        drain();
        check("done_count_wrap", 32'(done_count), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
